// File: rtl/plab4_net_router_alt_pkg.sv
// plab4_net_router_alt_pkg: message layout, port indices and route helper for the ring router
package plab4_net_router_alt_pkg;
  localparam int PAYLOAD_NBITS = 32;
  localparam int OPAQUE_NBITS = 3;
  localparam int SRCDEST_NBITS = 3;
  localparam int MSG_NBITS = PAYLOAD_NBITS + OPAQUE_NBITS + 2 * SRCDEST_NBITS;
  localparam int PAYLOAD_LSB = 0;
  localparam int OPAQUE_LSB = PAYLOAD_LSB + PAYLOAD_NBITS;
  localparam int SRC_LSB = OPAQUE_LSB + OPAQUE_NBITS;
  localparam int DEST_LSB = SRC_LSB + SRCDEST_NBITS;
  localparam logic [1:0] PORT_CCW = 2'd0;
  localparam logic [1:0] PORT_TERM = 2'd1;
  localparam logic [1:0] PORT_CW = 2'd2;
  typedef struct packed {
    logic [SRCDEST_NBITS-1:0] dest;
    logic [SRCDEST_NBITS-1:0] src;
    logic [OPAQUE_NBITS-1:0] opaque;
    logic [PAYLOAD_NBITS-1:0] payload;
  } net_msg_t;
  // minimal-hop direction; the half-ring tie goes clockwise
  function automatic logic [1:0] route_of(int dest, int id, int n);
    int d;
    d = (dest - id + n) % n;
    return d == 0 ? PORT_TERM : 2 * d <= n ? PORT_CW : PORT_CCW;
  endfunction
endpackage

// File: rtl/plab4_net_router_alt_if.sv
// plab4_net_router_alt_if: val/rdy message link between routers and terminals
interface plab4_net_router_alt_if
  import plab4_net_router_alt_pkg::*;
#(
  parameter int W = MSG_NBITS
);
  logic val;
  logic rdy;
  logic [W-1:0] msg;
  modport master(output val, output msg, input rdy);
  modport slave(input val, input msg, output rdy);
endinterface

// File: rtl/plab4_net_router_alt_arb.sv
// net_round_robin_arb: 3-requester round-robin arbiter, pointer advances past a fired winner
module net_round_robin_arb (
  input  logic clk,
  input  logic reset,
  input  logic [2:0] req,
  input  logic en,
  output logic [2:0] grant
);
  logic [1:0] ptr;
  logic [2:0] r, g;
  // rotate so bit 0 is the highest-priority requester, pick, rotate back
  assign r = ptr == 2'd1 ? {req[0], req[2], req[1]} : ptr == 2'd2 ? {req[1], req[0], req[2]} : req;
  assign g = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
  assign grant = ptr == 2'd1 ? {g[1], g[0], g[2]} : ptr == 2'd2 ? {g[0], g[2], g[1]} : g;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= 2'd0;
    else if (en && |grant) ptr <= grant[0] ? 2'd1 : grant[1] ? 2'd2 : 2'd0;
endmodule

// File: rtl/plab4_net_router_alt_input_queue.sv
// net_router_input_queue: 2-entry val/rdy FIFO without bypass
module net_router_input_queue #(
  parameter int W = 41
) (
  input  logic clk,
  input  logic reset,
  input  logic enq_val,
  output logic enq_rdy,
  input  logic [W-1:0] enq_msg,
  output logic deq_val,
  input  logic deq_rdy,
  output logic [W-1:0] deq_msg
);
  logic [W-1:0] mem [2];
  logic head, tail, enq, deq;
  logic [1:0] count;
  assign enq_rdy = reset && count != 2'd2;
  assign deq_val = count != 2'd0;
  assign deq_msg = mem[head];
  assign enq = enq_val && enq_rdy;
  assign deq = deq_val && deq_rdy;
  always_ff @(posedge clk)
    if (enq) mem[tail] <= enq_msg;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head <= 1'b0;
      tail <= 1'b0;
      count <= 2'd0;
    end else begin
      if (enq) tail <= ~tail;
      if (deq) head <= ~head;
      count <= count + {1'b0, enq} - {1'b0, deq};
    end
endmodule

// File: rtl/plab4_net_router_alt.sv
// plab4_net_router_alt: three-port ring router with per-input queues and per-output round-robin arbitration
module plab4_net_router_alt
  import plab4_net_router_alt_pkg::*;
#(
  parameter int p_payload_nbits = PAYLOAD_NBITS,
  parameter int p_opaque_nbits = OPAQUE_NBITS,
  parameter int p_srcdest_nbits = SRCDEST_NBITS,
  parameter int p_router_id = 0,
  parameter int p_num_routers = 8
) (
  input  logic clk,
  input  logic reset,
  plab4_net_router_alt_if.slave in0,
  plab4_net_router_alt_if.slave in1,
  plab4_net_router_alt_if.slave in2,
  plab4_net_router_alt_if.master out0,
  plab4_net_router_alt_if.master out1,
  plab4_net_router_alt_if.master out2,
  output logic out0_rdy_0,
  output logic out0_rdy_1,
  output logic out0_rdy_2,
  output logic out0_rdy_3,
  output logic out2_rdy_0,
  output logic out2_rdy_1,
  output logic out2_rdy_2,
  output logic out2_rdy_3
);
  localparam int M = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits;
  logic [2:0] in_val, in_rdy, head_val, deq, out_val, out_rdy;
  logic [M-1:0] in_msg [3];
  logic [M-1:0] head [3];
  logic [M-1:0] out_msg [3];
  logic [1:0] route [3];
  logic [2:0] req [3];
  logic [2:0] grant [3];
  assign in_val = {in2.val, in1.val, in0.val};
  assign in_msg[0] = in0.msg;
  assign in_msg[1] = in1.msg;
  assign in_msg[2] = in2.msg;
  assign in0.rdy = in_rdy[0];
  assign in1.rdy = in_rdy[1];
  assign in2.rdy = in_rdy[2];
  assign out_rdy = {out2.rdy, out1.rdy, out0.rdy};
  assign out0.val = out_val[0];
  assign out1.val = out_val[1];
  assign out2.val = out_val[2];
  assign out0.msg = out_msg[0];
  assign out1.msg = out_msg[1];
  assign out2.msg = out_msg[2];
  for (genvar i = 0; i < 3; i++) begin : g_port
    net_router_input_queue #(.W(M)) u_queue (
      .clk(clk), .reset(reset),
      .enq_val(in_val[i]), .enq_rdy(in_rdy[i]), .enq_msg(in_msg[i]),
      .deq_val(head_val[i]), .deq_rdy(deq[i]), .deq_msg(head[i])
    );
    assign route[i] = route_of(int'(head[i][M-1 -: p_srcdest_nbits]), p_router_id, p_num_routers);
    net_round_robin_arb u_arb (
      .clk(clk), .reset(reset), .req(req[i]), .en(out_rdy[i]), .grant(grant[i])
    );
  end
  always_comb
    for (int x = 0; x < 3; x++)
      for (int k = 0; k < 3; k++)
        req[x][k] = head_val[k] && route[k] == 2'(x);
  // each head requests exactly one output, so at most one grant can dequeue it
  always_comb begin
    deq = '0;
    for (int x = 0; x < 3; x++) begin
      out_val[x] = |grant[x];
      out_msg[x] = grant[x][1] ? head[1] : grant[x][2] ? head[2] : head[0];
      deq = deq | (grant[x] & {3{out_rdy[x]}});
    end
  end
  assign out0_rdy_0 = grant[0][0] && out_rdy[0];
  assign out0_rdy_1 = grant[0][1] && out_rdy[0];
  assign out0_rdy_2 = grant[0][2] && out_rdy[0];
  assign out0_rdy_3 = out_val[0] && out_rdy[0];
  assign out2_rdy_0 = grant[2][0] && out_rdy[2];
  assign out2_rdy_1 = grant[2][1] && out_rdy[2];
  assign out2_rdy_2 = grant[2][2] && out_rdy[2];
  assign out2_rdy_3 = out_val[2] && out_rdy[2];
endmodule

// File: tb/tb_plab4_net_router_alt.sv
// tb_plab4_net_router_alt: randomized scoreboard bench for the ring router at id 2 of 8
module tb_plab4_net_router_alt;
  import plab4_net_router_alt_pkg::*;
  localparam int ID = 2;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  plab4_net_router_alt_if i0(), i1(), i2(), o0(), o1(), o2();
  logic [2:0] in_val = '0;
  logic [2:0] out_rdy = '0;
  net_msg_t in_msg [3];
  net_msg_t out_msg [3];
  logic [2:0] in_rdy, out_val;
  logic [3:0] st0, st2;
  assign i0.val = in_val[0];
  assign i1.val = in_val[1];
  assign i2.val = in_val[2];
  assign i0.msg = in_msg[0];
  assign i1.msg = in_msg[1];
  assign i2.msg = in_msg[2];
  assign o0.rdy = out_rdy[0];
  assign o1.rdy = out_rdy[1];
  assign o2.rdy = out_rdy[2];
  assign in_rdy = {i2.rdy, i1.rdy, i0.rdy};
  assign out_val = {o2.val, o1.val, o0.val};
  assign out_msg[0] = o0.msg;
  assign out_msg[1] = o1.msg;
  assign out_msg[2] = o2.msg;

  plab4_net_router_alt #(.p_router_id(ID), .p_num_routers(N)) dut (
    .clk(clk), .reset(reset),
    .in0(i0), .in1(i1), .in2(i2), .out0(o0), .out1(o1), .out2(o2),
    .out0_rdy_0(st0[0]), .out0_rdy_1(st0[1]), .out0_rdy_2(st0[2]), .out0_rdy_3(st0[3]),
    .out2_rdy_0(st2[0]), .out2_rdy_1(st2[1]), .out2_rdy_2(st2[2]), .out2_rdy_3(st2[3])
  );

  int chk = 0;
  int pass = 0;
  int seq = 0;
  net_msg_t src_q [3][$];
  net_msg_t exp_q [3][3][$];

  // shorter way round wins; equal distance goes clockwise
  function automatic int model_port(int dest);
    int cw, ccw;
    cw = (dest - ID + N) % N;
    ccw = (ID - dest + N) % N;
    return cw == 0 ? 1 : (cw <= ccw ? 2 : 0);
  endfunction

  function automatic net_msg_t mk(int port, int dest, int opq);
    net_msg_t m;
    m.dest = 3'(dest);
    m.src = 3'($urandom_range(0, 7));
    m.opaque = 3'(opq);
    m.payload = {2'(port), 30'(seq)};
    seq++;
    return m;
  endfunction

  task automatic add_tx(int port, int dest, int opq);
    net_msg_t m;
    m = mk(port, dest, opq);
    src_q[port].push_back(m);
    exp_q[port][model_port(dest)].push_back(m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_val = '0;
    out_rdy = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_val = 3'b111;
    out_rdy = 3'b111;
    for (int i = 0; i < 3; i++) in_msg[i] = mk(i, 3, 0);
    #1;
    chk++;
    if ({in_rdy, out_val, st0, st2} !== 14'd0)
      $display("FAIL reset_hold: rdy=%b val=%b st0=%b st2=%b, required all 0", in_rdy, out_val, st0, st2);
    else pass++;
    @(negedge clk);
    in_val = '0;
    reset = 1'b1;
    #1;
    chk++;
    if (in_rdy !== 3'b111) $display("FAIL reset_release_rdy: %b, required 111", in_rdy);
    else pass++;
    chk++;
    if (out_val !== 3'b000) $display("FAIL reset_release_val: %b, required 000", out_val);
    else pass++;
  endtask

  task automatic run_traffic(int sd, int kd);
    int total, got, leftover;
    int dly [3];
    bit fired [3];
    bit extra;
    total = 0;
    got = 0;
    for (int i = 0; i < 3; i++) begin
      total += src_q[i].size();
      dly[i] = 0;
      fired[i] = 0;
    end
    for (int c = 0; c < 5000 && got < total; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (fired[i]) begin
          void'(src_q[i].pop_front());
          in_val[i] = 1'b0;
          dly[i] = $urandom_range(0, sd);
          fired[i] = 0;
        end
        if (!in_val[i] && src_q[i].size() > 0) begin
          if (dly[i] == 0) begin
            in_val[i] = 1'b1;
            in_msg[i] = src_q[i][0];
          end else dly[i]--;
        end
      end
      for (int x = 0; x < 3; x++) out_rdy[x] = $urandom_range(0, kd) == 0;
      #1;
      for (int i = 0; i < 3; i++) fired[i] = in_val[i] && in_rdy[i];
      for (int x = 0; x < 3; x++)
        if (out_val[x] && out_rdy[x]) begin
          net_msg_t m;
          int s;
          m = out_msg[x];
          s = int'(m.payload[31:30]);
          got++;
          chk++;
          if (s < 3 && exp_q[s][x].size() > 0 && exp_q[s][x][0] === m) begin
            pass++;
            void'(exp_q[s][x].pop_front());
          end else
            $display("FAIL traffic_out%0d: got %h, not the next message expected there", x, m);
        end
    end
    @(negedge clk);
    in_val = '0;
    out_rdy = 3'b111;
    leftover = 0;
    for (int i = 0; i < 3; i++) begin
      leftover += src_q[i].size();
      src_q[i].delete();
      for (int x = 0; x < 3; x++) begin
        leftover += exp_q[i][x].size();
        exp_q[i][x].delete();
      end
    end
    chk++;
    if (got !== total || leftover !== 0)
      $display("FAIL traffic_count: delivered %0d undelivered %0d, required %0d and 0", got, leftover, total);
    else pass++;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (out_val !== 3'b000) extra = 1;
      @(negedge clk);
    end
    chk++;
    if (extra) $display("FAIL traffic_extra: val seen after drain, required none");
    else pass++;
  endtask

  task automatic load_basic();
    add_tx(0, 3, 'h00); add_tx(2, 0, 'h05); add_tx(1, 2, 'h30);
    add_tx(2, 1, 'h10); add_tx(0, 4, 'h15); add_tx(2, 2, 'h32);
    add_tx(0, 3, 'h23); add_tx(0, 2, 'h31); add_tx(1, 1, 'h70);
  endtask

  task automatic test_basic();
    load_basic();
    run_traffic(0, 0);
  endtask

  task automatic test_delays();
    load_basic();
    run_traffic(3, 10);
    load_basic();
    run_traffic(10, 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      add_tx($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 7));
    run_traffic(2, 2);
  endtask

  // all three inputs to dest 3 at once, then check grant order in the given sequence
  task automatic burst(int a, int b, int c);
    net_msg_t m [3];
    int ord [3];
    ord = '{a, b, c};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      m[i] = mk(i, 3, i);
      in_msg[i] = m[i];
    end
    in_val = 3'b111;
    out_rdy = 3'b111;
    @(negedge clk);
    in_val = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k < 3) begin
        chk++;
        if (out_val !== 3'b100 || out_msg[2] !== m[ord[k]])
          $display("FAIL contention_grant%0d: val=%b msg=%h, required 100 and %h", k, out_val, out_msg[2], m[ord[k]]);
        else pass++;
        chk++;
        if (st2 !== {1'b1, 3'(1 << ord[k])})
          $display("FAIL contention_status%0d: st2=%b, required %b", k, st2, {1'b1, 3'(1 << ord[k])});
        else pass++;
      end else begin
        chk++;
        if (out_val !== 3'b000 || st2 !== 4'b0000)
          $display("FAIL contention_done: val=%b st2=%b, required 000 and 0000", out_val, st2);
        else pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    net_msg_t w;
    do_reset();
    burst(0, 1, 2);
    w = mk(1, 3, 5);
    in_msg[1] = w;
    in_val = 3'b010;
    @(negedge clk);
    in_val = '0;
    #1;
    chk++;
    if (out_val !== 3'b100 || out_msg[2] !== w)
      $display("FAIL contention_single: val=%b msg=%h, required 100 and %h", out_val, out_msg[2], w);
    else pass++;
    burst(2, 0, 1);
  endtask

  task automatic test_backpressure();
    net_msg_t a [3];
    net_msg_t b [6];
    int k0;
    do_reset();
    for (int i = 0; i < 3; i++) a[i] = mk(0, 4, i);
    for (int i = 0; i < 6; i++) b[i] = mk(1, 2, i);
    k0 = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_rdy = 3'b011;
      in_val[0] = k0 < 3;
      in_msg[0] = a[k0 < 3 ? k0 : 2];
      in_val[1] = 1'b1;
      in_msg[1] = b[c];
      #1;
      chk++;
      if (in_rdy[0] !== (c < 2)) $display("FAIL bp_in0_rdy%0d: %b, required %b", c, in_rdy[0], c < 2);
      else pass++;
      if (in_val[0] && in_rdy[0]) k0++;
      if (c > 0) begin
        chk++;
        if (out_val[1] !== 1'b1 || out_msg[1] !== b[c-1])
          $display("FAIL bp_out1_%0d: val=%b msg=%h, required 1 and %h", c, out_val[1], out_msg[1], b[c-1]);
        else pass++;
      end
      chk++;
      if (out_val[2] !== (c > 0) || st2 !== 4'b0000 || out_msg[2] !== (c > 0 ? a[0] : out_msg[2]))
        $display("FAIL bp_out2_%0d: val=%b st2=%b msg=%h, required %b, 0000, head %h", c, out_val[2], st2, out_msg[2], c > 0, a[0]);
      else pass++;
    end
    @(negedge clk);
    in_val = '0;
  endtask

  task automatic test_tie();
    net_msg_t m6, m7;
    do_reset();
    m6 = mk(1, 6, 1);
    m7 = mk(0, 7, 2);
    in_msg[1] = m6;
    in_msg[0] = m7;
    in_val = 3'b011;
    out_rdy = 3'b111;
    @(negedge clk);
    in_val = '0;
    #1;
    chk++;
    if (out_val[2] !== 1'b1 || out_msg[2] !== m6)
      $display("FAIL tie_dest6: out2 val=%b msg=%h, required 1 and %h", out_val[2], out_msg[2], m6);
    else pass++;
    chk++;
    if (out_val[0] !== 1'b1 || out_msg[0] !== m7 || st0 !== 4'b1001)
      $display("FAIL tie_dest7: out0 val=%b msg=%h st0=%b, required 1, %h, 1001", out_val[0], out_msg[0], st0, m7);
    else pass++;
    @(negedge clk);
  endtask

  task automatic test_midreset();
    bit stale;
    do_reset();
    @(negedge clk);
    in_msg[0] = mk(0, 4, 0);
    in_msg[2] = mk(2, 7, 0);
    in_val = 3'b101;
    @(negedge clk);
    in_msg[0] = mk(0, 4, 1);
    in_val = 3'b001;
    @(negedge clk);
    in_val = '0;
    #1;
    chk++;
    if (out_val !== 3'b101 || in_rdy !== 3'b110)
      $display("FAIL midreset_loaded: val=%b rdy=%b, required 101 and 110", out_val, in_rdy);
    else pass++;
    #1;
    reset = 1'b0;
    #1;
    chk++;
    if ({out_val, in_rdy, st0, st2} !== 14'd0)
      $display("FAIL midreset_async: val=%b rdy=%b st0=%b st2=%b, required all 0", out_val, in_rdy, st0, st2);
    else pass++;
    @(negedge clk);
    reset = 1'b1;
    out_rdy = 3'b111;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_val !== 3'b000 || in_rdy !== 3'b111) stale = 1;
      @(negedge clk);
    end
    chk++;
    if (stale) $display("FAIL midreset_after: stale valid or rdy low after release, required val 000 rdy 111");
    else pass++;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) in_msg[i] = '0;
    test_reset();
    test_basic();
    test_delays();
    test_random();
    test_contention();
    test_backpressure();
    test_tie();
    test_midreset();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
